camera_pixel_mem_writer: RTL and testbench

Streaming-to-memory stage that feeds the 32-bit single-port on-chip RAM (15-bit word address, 4-bit byteenable, 1-cycle write) through its write-side slave signals. Accepts 16-bit RGB565 pixels on a valid/ready stream with sop/eop framing. Packs pixel pairs into 32-bit words and writes one frame into a linear word region. Reports completion, word count and error flags to a control master.

---
 rtl/camera_mem_pkg.sv | 26 ++
 rtl/pixel_pair_packer.sv | 70 +++++++
 rtl/camera_pixel_mem_writer.sv | 214 +++++++++++++++++++++
 tb/tb_camera_pixel_mem_writer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_mem_pkg.sv
// -----------------------------------------------------------------------------
// camera_mem_pkg
//
// Shared definitions for the camera pixel-to-RAM writer:
//   - state_t    : frame capture FSM states
//   - PIX_W      : width of one RGB565 pixel
//   - WORD_W     : width of one RAM word (two pixels)
//   - BE_FULL    : byte enables for a complete pixel pair
//   - BE_LOW     : byte enables for a lone trailing pixel (low half only)
// -----------------------------------------------------------------------------
package camera_mem_pkg;

  localparam int PIX_W  = 16;
  localparam int WORD_W = 32;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_LOW  = 4'b0011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // waiting for start
    WAIT_SOP = 2'd1,  // armed, discarding pixels until a start-of-packet
    CAPTURE  = 2'd2,  // inside a frame, packing and writing pixels
    DONE     = 2'd3   // frame complete, one-cycle completion pulse
  } state_t;

endpackage : camera_mem_pkg

// File: rtl/pixel_pair_packer.sv
// -----------------------------------------------------------------------------
// pixel_pair_packer
//
// Packs a stream of 16-bit pixels into 32-bit words. The first pixel of each
// pair is held in a pending half-word register; the second pixel completes the
// word. A pixel flagged as last with no partner produces a zero-padded word
// with only the low byte lanes enabled.
//
// The word request is combinational on the accepted pixel so the parent can
// register the RAM write together with the address it owns.
//
// Ports:
//   clk        in   clock
//   reset_n    in   synchronous active-low reset
//   clear      in   discard any pending half-word
//   pix_valid  in   a frame pixel is being consumed this cycle
//   pix_first  in   this pixel starts a frame (always lands in the low half)
//   pix_last   in   this pixel ends a frame (flush a lone pending pixel)
//   pix_data   in   pixel value
//   word_req   out  a word is ready to be written this cycle
//   word_data  out  packed word {odd, even} or {16'h0, pixel}
//   word_be    out  byte enables for word_data
// -----------------------------------------------------------------------------
module pixel_pair_packer
  import camera_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              pix_valid,
  input  logic              pix_first,
  input  logic              pix_last,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              word_req,
  output logic [WORD_W-1:0] word_data,
  output logic [3:0]        word_be
);

  logic [PIX_W-1:0] half_q;
  logic             have_q;
  logic             pair_ready;

  // A start-of-frame pixel always restarts pairing, so a stale half-word from
  // an interrupted frame is never merged into the new one.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here unconditionally) so no latch is inferred.
  always_comb begin
    pair_ready = have_q & ~pix_first;
    word_req   = pix_valid & (pair_ready | pix_last);
    word_data  = pair_ready ? {pix_data, half_q} : {{PIX_W{1'b0}}, pix_data};
    word_be    = pair_ready ? BE_FULL : BE_LOW;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      half_q <= '0;
      have_q <= 1'b0;
    end else if (clear) begin
      have_q <= 1'b0;
    end else if (pix_valid) begin
      if (pair_ready || pix_last) begin
        have_q <= 1'b0;
      end else begin
        half_q <= pix_data;
        have_q <= 1'b1;
      end
    end
  end

endmodule : pixel_pair_packer

// File: rtl/camera_pixel_mem_writer.sv
// -----------------------------------------------------------------------------
// camera_pixel_mem_writer
//
// Streams one RGB565 frame from a valid/ready sink into a linear region of a
// 32-bit single-port RAM. Pixels are packed in pairs ({odd, even}); a frame
// with an odd pixel count ends with a low-half-only write. Writes are single
// cycle, so the sink never stalls while a frame is open.
//
// Parameters:
//   ADDR_W     RAM word-address width
//   DEPTH      number of RAM words a frame may occupy
//   BASE_WORD  first word address written for every frame
//
// Ports:
//   clk             in   clock
//   reset_n         in   synchronous active-low reset
//   start           in   pulse: arm capture of the next frame (ignored if busy)
//   abort           in   pulse: abandon the current frame
//   snk_data        in   pixel
//   snk_valid       in   pixel valid
//   snk_sop         in   first pixel of a frame
//   snk_eop         in   last pixel of a frame
//   snk_ready       out  pixel accepted when snk_valid & snk_ready
//   mem_address     out  RAM word address (holds outside write cycles)
//   mem_byteenable  out  byte lanes (0 outside write cycles)
//   mem_chipselect  out  RAM select (high only in write cycles)
//   mem_write       out  write strobe
//   mem_writedata   out  packed pixels (holds outside write cycles)
//   mem_clken       out  RAM clock enable, high from the first cycle after reset
//   busy            out  FSM not idle
//   frame_done      out  one-cycle completion pulse
//   words_written   out  words written in the last or current frame
//   overflow        out  sticky: the frame did not fit in DEPTH words
//   sop_err         out  sticky: a start-of-packet arrived mid-frame
// -----------------------------------------------------------------------------
module camera_pixel_mem_writer
  import camera_mem_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DEPTH     = 32000,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [PIX_W-1:0]  snk_data,
  input  logic              snk_valid,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   words_written,
  output logic              overflow,
  output logic              sop_err
);

  // One extra bit on the word counter so it can reach DEPTH itself, which is
  // the saturation point used to detect overflow.
  localparam logic [ADDR_W:0]   DEPTH_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   IDX_ONE   = 1;
  localparam logic [ADDR_W-1:0] BASE_ADDR = BASE_WORD[ADDR_W-1:0];

  state_t state_q, state_d;

  logic              accept;
  logic              take;
  logic              pix_valid;
  logic              pack_clear;
  logic              arm;
  logic              word_req;
  logic [WORD_W-1:0] word_data;
  logic [3:0]        word_be;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   idx_base;
  logic              at_limit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = WAIT_SOP;
      WAIT_SOP: begin
        if (abort)                 state_d = IDLE;
        else if (take && snk_sop)  state_d = snk_eop ? DONE : CAPTURE;
      end
      CAPTURE: begin
        if (abort)                 state_d = IDLE;
        else if (take && snk_eop)  state_d = DONE;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // The final write of a frame is registered on the eop edge, so it lands in
  // the same cycle the FSM sits in DONE.
  always_comb begin
    snk_ready  = (state_q == WAIT_SOP) || (state_q == CAPTURE);
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Stream qualification
  // ---------------------------------------------------------------------------
  // abort wins over a pixel offered in the same cycle: that pixel is consumed
  // but never reaches the packer. In WAIT_SOP only a sop pixel opens a frame;
  // everything else is dropped.
  always_comb begin
    accept     = snk_valid & snk_ready;
    take       = accept & ~abort;
    pix_valid  = take & ((state_q == CAPTURE) | snk_sop);
    arm        = (state_q == IDLE) & start;
    pack_clear = arm | (abort & snk_ready);
    // A sop restarts the frame at word 0, mid-frame or not.
    idx_base   = snk_sop ? '0 : word_idx;
    at_limit   = (idx_base == DEPTH_CNT);
  end

  pixel_pair_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (pack_clear),
    .pix_valid (pix_valid),
    .pix_first (snk_sop),
    .pix_last  (snk_eop),
    .pix_data  (snk_data),
    .word_req  (word_req),
    .word_data (word_data),
    .word_be   (word_be)
  );

  // ---------------------------------------------------------------------------
  // RAM write port, word counter and status flags
  // ---------------------------------------------------------------------------
  // Strobes default low every cycle; address and data only move on a write.
  // Once the counter reaches DEPTH further words are dropped but the stream
  // is still drained to eop so the frame completes normally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      mem_clken      <= 1'b0;
      word_idx       <= '0;
      overflow       <= 1'b0;
      sop_err        <= 1'b0;
    end else begin
      mem_clken      <= 1'b1;
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_byteenable <= '0;

      if (arm) begin
        word_idx <= '0;
        overflow <= 1'b0;
        sop_err  <= 1'b0;
      end else if (pix_valid) begin
        if ((state_q == CAPTURE) && snk_sop) sop_err <= 1'b1;

        if (word_req && !at_limit) begin
          mem_write      <= 1'b1;
          mem_chipselect <= 1'b1;
          mem_byteenable <= word_be;
          mem_writedata  <= word_data;
          mem_address    <= BASE_ADDR + idx_base[ADDR_W-1:0];
          word_idx       <= idx_base + IDX_ONE;
        end else begin
          word_idx <= idx_base;
        end

        if (word_req && at_limit) overflow <= 1'b1;
      end
    end
  end

  assign words_written = word_idx;

  // ---------------------------------------------------------------------------
  // Configuration check: the whole frame region must be addressable.
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  localparam longint LAST_WORD = longint'(BASE_WORD) + longint'(DEPTH) - longint'(1);
  localparam longint ADDR_MAX  = (longint'(1) << ADDR_W) - longint'(1);

  a_region_fits: assert property (@(posedge clk) LAST_WORD <= ADDR_MAX);
`endif

endmodule : camera_pixel_mem_writer

// File: tb/tb_camera_pixel_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_camera_pixel_mem_writer
//
// Two instances share one stimulus stream: the default configuration and a
// DEPTH=4 copy that exercises the overflow path. Expected RAM writes are
// pushed to one queue per instance as pixels are driven and popped when the
// instance strobes mem_write. Whole frames come from a vector table; the
// mid-frame sop, abort and reset cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_camera_pixel_mem_writer;
  import camera_mem_pkg::*;

  localparam int ADDR_W = 15;
  localparam int SMALL_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [15:0]       snk_data = '0;
  logic              snk_valid = 1'b0;
  logic              snk_sop = 1'b0;
  logic              snk_eop = 1'b0;

  logic              snk_ready, snk_ready_s;
  logic [ADDR_W-1:0] mem_address, mem_address_s;
  logic [3:0]        mem_byteenable, mem_byteenable_s;
  logic              mem_chipselect, mem_chipselect_s;
  logic              mem_write, mem_write_s;
  logic [31:0]       mem_writedata, mem_writedata_s;
  logic              mem_clken, mem_clken_s;
  logic              busy, busy_s;
  logic              frame_done, frame_done_s;
  logic [ADDR_W:0]   words_written, words_written_s;
  logic              overflow, overflow_s;
  logic              sop_err, sop_err_s;

  camera_pixel_mem_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
    .snk_ready(snk_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .busy(busy), .frame_done(frame_done),
    .words_written(words_written), .overflow(overflow), .sop_err(sop_err)
  );

  camera_pixel_mem_writer #(.DEPTH(SMALL_DEPTH)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
    .snk_ready(snk_ready_s), .mem_address(mem_address_s), .mem_byteenable(mem_byteenable_s),
    .mem_chipselect(mem_chipselect_s), .mem_write(mem_write_s), .mem_writedata(mem_writedata_s),
    .mem_clken(mem_clken_s), .busy(busy_s), .frame_done(frame_done_s),
    .words_written(words_written_s), .overflow(overflow_s), .sop_err(sop_err_s)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: expected writes {address, data, byteenable}
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  wr_t q_main[$];
  wr_t q_small[$];
  wr_t e_main, e_small;

  // Reference packing model: pairs become {odd, even}, a lone last pixel is
  // zero-padded in the low half. The small instance only sees the first
  // SMALL_DEPTH words of a frame.
  logic [15:0] m_half;
  bit          m_have;
  int          m_idx;

  task automatic push_word(input logic [31:0] data, input logic [3:0] be);
    q_main.push_back('{addr: ADDR_W'(m_idx), data: data, be: be});
    if (m_idx < SMALL_DEPTH) q_small.push_back('{addr: ADDR_W'(m_idx), data: data, be: be});
    m_idx++;
  endtask

  task automatic model_pixel(input logic [15:0] d, input bit sop, input bit eop);
    if (sop) begin
      m_have = 1'b0;
      m_idx  = 0;
    end
    if (m_have) begin
      push_word({d, m_half}, 4'b1111);
      m_have = 1'b0;
    end else if (eop) begin
      push_word({16'h0000, d}, 4'b0011);
    end else begin
      m_half = d;
      m_have = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_done) fd_count++;

      if (mem_write) begin
        check("cs_main", 64'(mem_chipselect), 64'd1);
        if (q_main.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wr_main_unexpected: got addr %h data %h be %h expected no write",
                   mem_address, mem_writedata, mem_byteenable);
        end else begin
          e_main = q_main.pop_front();
          check("wr_main", 64'({mem_address, mem_writedata, mem_byteenable}), 64'(e_main));
        end
      end else begin
        check("idle_main", 64'({mem_chipselect, mem_byteenable}), 64'd0);
      end

      if (mem_write_s) begin
        check("cs_small", 64'(mem_chipselect_s), 64'd1);
        if (q_small.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wr_small_unexpected: got addr %h data %h be %h expected no write",
                   mem_address_s, mem_writedata_s, mem_byteenable_s);
        end else begin
          e_small = q_small.pop_front();
          check("wr_small", 64'({mem_address_s, mem_writedata_s, mem_byteenable_s}), 64'(e_small));
        end
      end else begin
        check("idle_small", 64'({mem_chipselect_s, mem_byteenable_s}), 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    m_have = 1'b0;
    m_idx  = 0;
    tick();
    start = 1'b0;
  endtask

  // Drives n back-to-back pixels base, base+step, ...; start_busy pulses start
  // alongside the second pixel, which must have no effect mid-frame.
  task automatic send_frame(input int n, input logic [15:0] base, input logic [15:0] step,
                            input bit with_sop, input bit with_eop, input bit start_busy);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d         = base + 16'(i) * step;
      snk_valid = 1'b1;
      snk_data  = d;
      snk_sop   = with_sop && (i == 0);
      snk_eop   = with_eop && (i == n - 1);
      start     = start_busy && (i == 1);
      model_pixel(d, snk_sop, snk_eop);
      tick();
    end
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (frame_done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_done"}, 64'(found), 64'd1);
    check({name, "_done_small"}, 64'(frame_done_s), 64'd1);
    tick();
    check({name, "_done_pulse"}, 64'(frame_done), 64'd0);
    check({name, "_idle"}, 64'({busy, busy_s}), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Frame vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          n;
    logic [15:0] base;
    logic [15:0] step;
    int          ww;
    int          ww_s;
    logic        ovf_s;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd_before;

    vecs[0] = '{4,  16'h1111, 16'h1111, 2, 2, 1'b0};  // two full pairs
    vecs[1] = '{3,  16'h000A, 16'h0001, 2, 2, 1'b0};  // pair + partial
    vecs[2] = '{1,  16'hBEEF, 16'h0000, 1, 1, 1'b0};  // sop and eop together
    vecs[3] = '{12, 16'h0100, 16'h0001, 6, 4, 1'b1};  // overflows DEPTH=4
    vecs[4] = '{7,  16'h8000, 16'h0101, 4, 4, 1'b0};  // fills DEPTH=4 exactly
    vecs[5] = '{9,  16'hC000, 16'h0003, 5, 4, 1'b1};  // partial word past DEPTH

    // Reset state
    tick();
    tick();
    mon_en = 1'b1;
    check("rst_clken", 64'({mem_clken, mem_clken_s}), 64'd0);
    check("rst_ctrl", 64'({busy, snk_ready, frame_done, overflow, sop_err}), 64'd0);
    check("rst_mem", 64'({mem_write, mem_chipselect, mem_byteenable, mem_address}), 64'd0);
    check("rst_wdata", 64'(mem_writedata), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    reset_n = 1'b1;
    tick();
    check("clken_on", 64'({mem_clken, mem_clken_s}), 64'd3);
    check("idle_ready", 64'(snk_ready), 64'd0);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      do_start();
      check($sformatf("v%0d_armed", v), 64'({busy, snk_ready}), 64'd3);
      // A pixel without sop while armed is consumed and dropped.
      snk_valid = 1'b1;
      snk_data  = 16'hDEAD;
      tick();
      snk_valid = 1'b0;
      send_frame(vecs[v].n, vecs[v].base, vecs[v].step, 1'b1, 1'b1, vecs[v].n > 2);
      wait_done($sformatf("v%0d", v));
      check($sformatf("v%0d_words", v), 64'(words_written), 64'(vecs[v].ww));
      check($sformatf("v%0d_words_small", v), 64'(words_written_s), 64'(vecs[v].ww_s));
      check($sformatf("v%0d_ovf", v), 64'(overflow), 64'd0);
      check($sformatf("v%0d_ovf_small", v), 64'(overflow_s), 64'(vecs[v].ovf_s));
      check($sformatf("v%0d_soperr", v), 64'({sop_err, sop_err_s}), 64'd0);
      tick();
    end

    // New sop mid-frame: pending pixel discarded, second frame restarts at @0
    do_start();
    send_frame(5, 16'h5000, 16'h0001, 1'b1, 1'b0, 1'b0);
    send_frame(2, 16'h6000, 16'h0001, 1'b1, 1'b1, 1'b0);
    wait_done("sopmid");
    check("sopmid_err", 64'({sop_err, sop_err_s}), 64'd3);
    check("sopmid_words", 64'({words_written, words_written_s}), {32'd0, 16'd1, 16'd1});

    // Abort after three pixels: one pair written, the third never flushed
    do_start();
    check("start_clears_soperr", 64'({sop_err, sop_err_s}), 64'd0);
    send_frame(3, 16'h7000, 16'h0001, 1'b1, 1'b0, 1'b0);
    fd_before = fd_count;
    abort = 1'b1;
    m_have = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_idle", 64'({busy, snk_ready, busy_s}), 64'd0);
    tick();
    tick();
    check("abort_no_done", 64'(fd_count), 64'(fd_before));
    check("abort_words", 64'(words_written), 64'd1);

    // Reset mid-frame: the already-registered write completes, then all clear
    do_start();
    send_frame(2, 16'h9000, 16'h0001, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    check("midrst_ctrl", 64'({busy, snk_ready, frame_done, overflow, sop_err, mem_clken}), 64'd0);
    check("midrst_mem", 64'({mem_write, mem_chipselect, mem_byteenable, mem_address}), 64'd0);
    check("midrst_wdata", 64'(mem_writedata), 64'd0);
    check("midrst_words", 64'({words_written, words_written_s}), 64'd0);
    reset_n = 1'b1;
    tick();
    check("midrst_clken", 64'(mem_clken), 64'd1);
    tick();

    check("q_main_empty", 64'(q_main.size()), 64'd0);
    check("q_small_empty", 64'(q_small.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_camera_pixel_mem_writer
